mul_div_unit: RTL and testbench

- Iterative 8-bit unsigned multiply/divide coprocessor beside the register file.
- Consumes the register file's two read-port values as operands.
- Produces a one-cycle write-back request (load enable, destination index, data) that drives the register file's write port, through the write-back mux.
- Used for MUL/DIV/REM instructions that a single-cycle ALU cannot complete; the core stalls while busy is high.

---
 rtl/mul_div_unit.sv | 177 +++++++++++++++++
 tb/tb_mul_div_unit.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide coprocessor: 8 shift-add or restoring-division
// iterations, followed by a single-cycle register-file write-back request.
module mul_div_unit #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [2:0]       dest,
    output logic             busy,
    output logic             wb_ld,
    output logic [2:0]       wb_dr,
    output logic [WIDTH-1:0] wb_data
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] low_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [1:0]       op_r;
    logic [2:0]       dest_r;

    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH:0]   div_sh_s;
    logic [WIDTH-1:0] div_diff_s;
    logic             div_ge_s;
    logic [WIDTH-1:0] acc_nxt_s;
    logic [WIDTH-1:0] low_nxt_s;
    logic [WIDTH-1:0] res_s;
    logic             last_s;
    logic             busy_nxt_s;
    logic             wb_ld_nxt_s;

    assign last_s = (cnt_r == CNT_LAST);

    // One iteration: acc/low are {hi,lo} of the product for MUL and {R,Q} for DIV.
    // R never exceeds WIDTH bits, so the trial difference only needs WIDTH bits.
    always_comb begin
        mul_sum_s  = {1'b0, acc_r} + (low_r[0] ? {1'b0, a_r} : {(WIDTH+1){1'b0}});
        div_sh_s   = {acc_r, low_r[WIDTH-1]};
        div_ge_s   = (div_sh_s >= {1'b0, b_r});
        div_diff_s = div_sh_s[WIDTH-1:0] - b_r;
        acc_nxt_s  = acc_r;
        low_nxt_s  = low_r;
        if (op_r[1] == 1'b0) begin
            acc_nxt_s = mul_sum_s[WIDTH:1];
            low_nxt_s = {mul_sum_s[0], low_r[WIDTH-1:1]};
        end else if (div_ge_s) begin
            acc_nxt_s = div_diff_s;
            low_nxt_s = {low_r[WIDTH-2:0], 1'b1};
        end else begin
            acc_nxt_s = div_sh_s[WIDTH-1:0];
            low_nxt_s = {low_r[WIDTH-2:0], 1'b0};
        end
        res_s = op_r[0] ? acc_nxt_s : low_nxt_s;
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; start is only honoured in IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_nxt_s = WB;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            WB:      state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output decode from the upcoming state so busy/wb_ld can be registered.
    always_comb begin
        busy_nxt_s  = 1'b0;
        wb_ld_nxt_s = 1'b0;
        case (state_nxt_s)
            RUN: begin
                busy_nxt_s  = 1'b1;
                wb_ld_nxt_s = 1'b0;
            end
            WB: begin
                busy_nxt_s  = 1'b1;
                wb_ld_nxt_s = 1'b1;
            end
            default: begin
                busy_nxt_s  = 1'b0;
                wb_ld_nxt_s = 1'b0;
            end
        endcase
    end

    // Registered control outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            busy  <= 1'b0;
            wb_ld <= 1'b0;
        end else begin
            busy  <= busy_nxt_s;
            wb_ld <= wb_ld_nxt_s;
        end
    end

    // Operand capture, iteration datapath and write-back data/index registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_r   <= {CW{1'b0}};
            acc_r   <= {WIDTH{1'b0}};
            low_r   <= {WIDTH{1'b0}};
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            op_r    <= 2'b00;
            dest_r  <= 3'd0;
            wb_dr   <= 3'd0;
            wb_data <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_r    <= op_a;
                        b_r    <= op_b;
                        op_r   <= op;
                        dest_r <= dest;
                        cnt_r  <= {CW{1'b0}};
                        acc_r  <= {WIDTH{1'b0}};
                        low_r  <= op[1] ? op_a : op_b;
                    end
                end
                RUN: begin
                    cnt_r <= cnt_r + CW'(1);
                    acc_r <= acc_nxt_s;
                    low_r <= low_nxt_s;
                    if (last_s) begin
                        wb_dr   <= dest_r;
                        wb_data <= res_s;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: expected write-backs are queued at start time
// and compared by a monitor whenever wb_ld pulses.
module tb_mul_div_unit;

    logic       CLK;
    logic       RESET;
    logic       start;
    logic [1:0] op;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [2:0] dest;
    logic       busy;
    logic       wb_ld;
    logic [2:0] wb_dr;
    logic [7:0] wb_data;

    int checks   = 0;
    int failures = 0;
    logic [10:0] sb_q[$];

    mul_div_unit #(.WIDTH(8)) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .start   (start),
        .op      (op),
        .op_a    (op_a),
        .op_b    (op_b),
        .dest    (dest),
        .busy    (busy),
        .wb_ld   (wb_ld),
        .wb_dr   (wb_dr),
        .wb_data (wb_data)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every write-back must match the oldest queued expectation.
    always @(negedge CLK) begin
        if (wb_ld === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_wb_ld", 16'(sb_q.size()), 16'd1);
            end else begin
                logic [10:0] e;
                e = sb_q.pop_front();
                chk("wb_dr", 16'(wb_dr), 16'(e[10:8]));
                chk("wb_data", 16'(wb_data), 16'(e[7:0]));
            end
        end
    end

    task automatic run_op(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] d, input logic [7:0] exp);
        op = o; op_a = a; op_b = b; dest = d; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        sb_q.push_back({d, exp});
        op = ~o; op_a = 8'($urandom); op_b = 8'($urandom); dest = ~d;
        for (int i = 0; i < 8; i++) begin
            chk("busy_run", 16'(busy), 16'd1);
            chk("wb_ld_run", 16'(wb_ld), 16'd0);
            @(posedge CLK); #1;
        end
        chk("busy_wb", 16'(busy), 16'd1);
        chk("wb_ld_wb", 16'(wb_ld), 16'd1);
        @(posedge CLK); #1;
        chk("busy_idle", 16'(busy), 16'd0);
        chk("wb_ld_idle", 16'(wb_ld), 16'd0);
    endtask

    initial begin
        RESET = 1'b1; start = 1'b0; op = 2'b00; op_a = 8'h00; op_b = 8'h00; dest = 3'd0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_wb_ld", 16'(wb_ld), 16'd0);
        chk("rst_wb_dr", 16'(wb_dr), 16'd0);
        chk("rst_wb_data", 16'(wb_data), 16'd0);
        RESET = 1'b0;
        @(posedge CLK); #1;

        run_op(2'b00, 8'd13,  8'd11,  3'd3, 8'h8F);
        run_op(2'b01, 8'd13,  8'd11,  3'd3, 8'h00);
        run_op(2'b00, 8'd200, 8'd200, 3'd2, 8'h40);
        run_op(2'b01, 8'd200, 8'd200, 3'd2, 8'h9C);
        run_op(2'b01, 8'd255, 8'd255, 3'd7, 8'hFE);
        run_op(2'b10, 8'd100, 8'd7,   3'd5, 8'h0E);
        run_op(2'b11, 8'd100, 8'd7,   3'd5, 8'h02);
        run_op(2'b10, 8'h25,  8'h00,  3'd4, 8'hFF);
        run_op(2'b11, 8'h25,  8'h00,  3'd6, 8'h25);

        // Start pulses during RUN and during WB must be ignored.
        op = 2'b00; op_a = 8'd3; op_b = 8'd4; dest = 3'd1; start = 1'b1;
        @(posedge CLK); #1;
        sb_q.push_back({3'd1, 8'd12});
        for (int c = 1; c <= 10; c++) begin
            if (c == 4 || c == 9) begin
                start = 1'b1; op = 2'b10; op_a = 8'hAA; op_b = 8'h03; dest = 3'd6;
            end else begin
                start = 1'b0;
            end
            @(posedge CLK); #1;
            chk("busy_ignore", 16'(busy), (c <= 8) ? 16'd1 : 16'd0);
            chk("wb_ld_ignore", 16'(wb_ld), (c == 8) ? 16'd1 : 16'd0);
        end
        start = 1'b0;
        repeat (12) @(posedge CLK);
        #1;
        chk("sb_drained_ignore", 16'(sb_q.size()), 16'd0);

        // Reset during the 5th RUN cycle aborts the divide with no write-back.
        op = 2'b10; op_a = 8'd100; op_b = 8'd7; dest = 3'd6; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        chk("abort_busy", 16'(busy), 16'd0);
        chk("abort_wb_ld", 16'(wb_ld), 16'd0);
        chk("abort_wb_dr", 16'(wb_dr), 16'd0);
        chk("abort_wb_data", 16'(wb_data), 16'd0);
        repeat (12) @(posedge CLK);
        #1;

        run_op(2'b10, 8'd200, 8'd9, 3'd0, 8'h16);
        run_op(2'b11, 8'd200, 8'd9, 3'd7, 8'h02);

        repeat (3) @(posedge CLK);
        #1;
        chk("sb_drained_end", 16'(sb_q.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
